mux_scan_reg: RTL

Parametrised, registered N-channel word multiplexer. It drives the board LEDs from one of CH_NUM input words. In manual mode the channel is chosen by switches. In scan mode the channel auto-rotates every DWELL clock cycles. A hold input freezes the display, and index/valid/wrap outputs let downstream logic (7-seg, debug) track which channel is shown.

---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_dwell_cnt.sv | 40 ++++
 rtl/mux_scan_reg.sv | 93 +++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the scanning LED word multiplexer.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Ceiling log2. Returns 0 for v <= 1, so callers clamp to a minimum width of 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_dwell_cnt.sv
// Dwell timer for scan mode: counts 0..DWELL-1 while enabled and flags the last cycle.
module mux_dwell_cnt
  import mux_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST_CNT);
  assign tick    = en && at_last;

  // Next count: clear wins, otherwise count and roll over at the last dwell cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mux_scan_reg.sv
// Registered N-channel word mux driving the LEDs, with manual select, timed scan and hold.
module mux_scan_reg
  import mux_pkg::*;
#(
  parameter  int CH_NUM = 4,
  parameter  int DATA_W = 8,
  parameter  int DWELL  = 4,
  localparam int SEL_W  = (clog2(CH_NUM) < 1) ? 1 : clog2(CH_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_NUM*DATA_W-1:0] din,
  input  logic [SEL_W-1:0]         sw,
  input  logic                     mode,
  input  logic                     hold,
  output logic [DATA_W-1:0]        led,
  output logic [SEL_W-1:0]         ch_idx,
  output logic                     ch_valid,
  output logic                     wrap
);

  // One extra bit so CH_NUM itself fits when it is a power of two.
  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W + 1)'(CH_NUM);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CH_NUM - 1);

  logic [DATA_W-1:0] led_q, led_d;
  logic [SEL_W-1:0]  ch_idx_q, next_idx;
  logic              ch_valid_q, ch_valid_d;
  logic              wrap_q, wrap_d;
  logic              cnt_en, cnt_clr, tick;

  // Counter runs only while scanning; manual mode keeps it at zero; hold freezes it.
  assign cnt_en  = (mode == MODE_SCAN)   && !hold;
  assign cnt_clr = (mode == MODE_MANUAL) && !hold;

  mux_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tick (tick)
  );

  // Next index, selected word and pulse flags; hold keeps everything and drops pulses.
  always_comb begin
    next_idx = ch_idx_q;
    wrap_d   = 1'b0;
    if (!hold) begin
      if (mode == MODE_MANUAL) begin
        if ({1'b0, sw} < CH_LIM) next_idx = sw;
      end else if (tick) begin
        if (ch_idx_q == LAST_IDX) begin
          next_idx = '0;
          wrap_d   = 1'b1;
        end else begin
          next_idx = ch_idx_q + 1'b1;
        end
      end
    end

    led_d = led_q;
    if (!hold) begin
      for (int k = 0; k < CH_NUM; k++) begin
        if (next_idx == SEL_W'(k)) led_d = din[k*DATA_W +: DATA_W];
      end
    end

    ch_valid_d = (next_idx != ch_idx_q);
  end

  // Output and index registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q      <= '0;
      ch_idx_q   <= '0;
      ch_valid_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      led_q      <= led_d;
      ch_idx_q   <= next_idx;
      ch_valid_q <= ch_valid_d;
      wrap_q     <= wrap_d;
    end
  end

  assign led      = led_q;
  assign ch_idx   = ch_idx_q;
  assign ch_valid = ch_valid_q;
  assign wrap     = wrap_q;

endmodule
